// File: rtl/led_matrix_scanner.sv
// Row-scanning driver for the 8x8 LED play-field.
// Each row is shifted MSB first into a 16-bit chain (8 column bits, then 8 row-select bits), latched, and held.
module led_matrix_scanner #(
  parameter int unsigned DIV          = 2,
  parameter int unsigned HOLD         = 64,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] matrix [0:7],
  input  logic       game_state,
  output logic       ser_data,
  output logic       ser_clk,
  output logic       ser_latch,
  output logic [2:0] row_idx,
  output logic       frame_done
);

  localparam int unsigned CNT_MAX = (DIV > HOLD) ? DIV : HOLD;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned BW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH,
    ST_HOLD
  } state_t;

  state_t          r_state, w_state;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [3:0]      r_bit, w_bit;
  logic [15:0]     r_word, w_word;
  logic [7:0]      r_snap [0:7];
  logic [7:0]      w_snap [0:7];
  logic [2:0]      r_row, w_row;
  logic            r_blink_on, w_blink_on;
  logic [BW-1:0]   r_blink_cnt, w_blink_cnt;
  logic            r_gs, w_gs;
  logic            r_ser_data, w_ser_data;
  logic            r_ser_clk, w_ser_clk;
  logic            r_ser_latch, w_ser_latch;
  logic            r_frame_done, w_frame_done;

  logic [7:0]      w_row_bits;
  logic [7:0]      w_mask;
  logic [15:0]     w_load_word;

  // Row 0 reads the live matrix because its snapshot is being taken in the same LOAD cycle.
  always_comb begin
    w_row_bits  = (r_row == 3'd0) ? matrix[0] : r_snap[r_row];
    w_mask      = (game_state || r_blink_on) ? 8'hFF : 8'h00;
    w_load_word = {w_row_bits & w_mask, 8'h80 >> r_row};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_LOAD;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_word       <= '0;
      r_snap       <= '{default: 8'h00};
      r_row        <= '0;
      r_blink_on   <= 1'b1;
      r_blink_cnt  <= '0;
      r_gs         <= 1'b1;
      r_ser_data   <= 1'b0;
      r_ser_clk    <= 1'b0;
      r_ser_latch  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_bit        <= w_bit;
      r_word       <= w_word;
      r_snap       <= w_snap;
      r_row        <= w_row;
      r_blink_on   <= w_blink_on;
      r_blink_cnt  <= w_blink_cnt;
      r_gs         <= w_gs;
      r_ser_data   <= w_ser_data;
      r_ser_clk    <= w_ser_clk;
      r_ser_latch  <= w_ser_latch;
      r_frame_done <= w_frame_done;
    end
  end

  // Serial outputs are decoded from the next state so they register in step with the state they belong to.
  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt + CW'(1);
    w_bit        = r_bit;
    w_word       = r_word;
    w_snap       = r_snap;
    w_row        = r_row;
    w_blink_on   = r_blink_on;
    w_blink_cnt  = r_blink_cnt;
    w_gs         = r_gs;
    w_ser_data   = r_ser_data;
    w_ser_clk    = r_ser_clk;
    w_ser_latch  = r_ser_latch;
    w_frame_done = 1'b0;

    case (r_state)
      ST_LOAD: begin
        if (r_row == 3'd0) w_snap = matrix;
        w_gs        = game_state;
        w_word      = w_load_word;
        w_bit       = 4'd15;
        w_cnt       = '0;
        w_state     = ST_SHIFT_LO;
        w_ser_data  = w_load_word[15];
        w_ser_clk   = 1'b0;
        w_ser_latch = 1'b0;
      end

      ST_SHIFT_LO: begin
        if (r_cnt == CW'(DIV - 1)) begin
          w_cnt     = '0;
          w_state   = ST_SHIFT_HI;
          w_ser_clk = 1'b1;
        end
      end

      ST_SHIFT_HI: begin
        if (r_cnt == CW'(DIV - 1)) begin
          w_cnt     = '0;
          w_ser_clk = 1'b0;
          if (r_bit == 4'd0) begin
            w_state     = ST_LATCH;
            w_ser_latch = 1'b1;
            w_ser_data  = 1'b0;
          end else begin
            w_bit      = r_bit - 4'd1;
            w_state    = ST_SHIFT_LO;
            w_ser_data = r_word[4'(r_bit - 4'd1)];
          end
        end
      end

      ST_LATCH: begin
        if (r_cnt == CW'(DIV - 1)) begin
          w_cnt       = '0;
          w_state     = ST_HOLD;
          w_ser_latch = 1'b0;
        end
      end

      ST_HOLD: begin
        if (r_cnt == CW'(HOLD - 1)) begin
          w_cnt   = '0;
          w_state = ST_LOAD;
          if (r_row == 3'd7) begin
            w_frame_done = 1'b1;
            w_row        = 3'd0;
            // Blink phase advances once per finished frame while the game is over.
            if (!r_gs) begin
              if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                w_blink_cnt = '0;
                w_blink_on  = ~r_blink_on;
              end else begin
                w_blink_cnt = r_blink_cnt + BW'(1);
              end
            end else begin
              w_blink_cnt = '0;
              w_blink_on  = 1'b1;
            end
          end else begin
            w_row = r_row + 3'd1;
          end
        end
      end

      default: begin
        w_state = ST_LOAD;
        w_cnt   = '0;
      end
    endcase
  end

  assign ser_data   = r_ser_data;
  assign ser_clk    = r_ser_clk;
  assign ser_latch  = r_ser_latch;
  assign row_idx    = r_row;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner: a default-timing instance and a DIV=1/HOLD=1 instance, decoded by a
// shift-register model and compared against per-frame expectations derived from cycle arithmetic.
module tb_led_matrix_scanner;

  localparam int unsigned DIV_A = 2, HOLD_A = 64, BF_A = 32;
  localparam int unsigned DIV_B = 1, HOLD_B = 1,  BF_B = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] matrix [0:7];
  logic       game_state;

  logic       o_data  [2];
  logic       o_sclk  [2];
  logic       o_latch [2];
  logic [2:0] o_row   [2];
  logic       o_fd    [2];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  led_matrix_scanner #(.DIV(DIV_A), .HOLD(HOLD_A), .BLINK_FRAMES(BF_A)) u_dut_a (
    .clk(clk), .reset(reset), .matrix(matrix), .game_state(game_state),
    .ser_data(o_data[0]), .ser_clk(o_sclk[0]), .ser_latch(o_latch[0]),
    .row_idx(o_row[0]), .frame_done(o_fd[0])
  );

  led_matrix_scanner #(.DIV(DIV_B), .HOLD(HOLD_B), .BLINK_FRAMES(BF_B)) u_dut_b (
    .clk(clk), .reset(reset), .matrix(matrix), .game_state(game_state),
    .ser_data(o_data[1]), .ser_clk(o_sclk[1]), .ser_latch(o_latch[1]),
    .row_idx(o_row[1]), .frame_done(o_fd[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned f_div(input int d);
    return (d == 0) ? DIV_A : DIV_B;
  endfunction

  function automatic int unsigned f_bf(input int d);
    return (d == 0) ? BF_A : BF_B;
  endfunction

  function automatic int unsigned f_period(input int d);
    return (d == 0) ? (1 + 33 * DIV_A + HOLD_A) : (1 + 33 * DIV_B + HOLD_B);
  endfunction

  // Reference model: rows start every row-period cycles after reset release; a frame is 8 rows.
  int unsigned cyc;
  logic [7:0]  snap [2][0:7];
  int unsigned go_frames [2];
  logic        gs_last [2];
  logic [18:0] ebuf [2][0:7];
  int unsigned wp [2];
  int unsigned rp [2];
  int unsigned m_p, m_r;
  logic [7:0]  m_mask;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      cyc = 0;
      for (int d = 0; d < 2; d++) begin
        wp[d] = 0; rp[d] = 0; go_frames[d] = 0; gs_last[d] = 1'b1;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_p = f_period(d);
        if (cyc % m_p == 0) begin
          m_r = (cyc / m_p) % 8;
          if (m_r == 0) begin
            if (cyc > 0) go_frames[d] = gs_last[d] ? 0 : go_frames[d] + 1;
            for (int i = 0; i < 8; i++) snap[d][i] = matrix[i];
          end
          if (m_r == 7) gs_last[d] = game_state;
          m_mask = (game_state || ((go_frames[d] / f_bf(d)) % 2 == 0)) ? 8'hFF : 8'h00;
          ebuf[d][wp[d] % 8] = {3'(m_r), snap[d][m_r] & m_mask, 8'h80 >> m_r};
          wp[d]++;
        end
      end
      cyc++;
    end
  end

  // Monitor: shift chain clocked on ser_clk rising, captured on ser_latch rising.
  logic [15:0] sr [2];
  int unsigned nsh [2];
  int unsigned nlatch [2];
  logic        pclk [2], platch [2], pdata [2];
  logic [18:0] m_e;

  initial begin
    for (int d = 0; d < 2; d++) nlatch[d] = 0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (reset) begin
          check($sformatf("dut%0d rst_outputs", d),
                32'({o_data[d], o_sclk[d], o_latch[d], o_row[d], o_fd[d]}), 32'd0);
          sr[d] = '0; nsh[d] = 0; pclk[d] = 1'b0; platch[d] = 1'b0; pdata[d] = 1'b0;
        end else begin
          if (o_sclk[d])
            check($sformatf("dut%0d data_stable", d), 32'(o_data[d]), 32'(pdata[d]));
          if (o_sclk[d] && !pclk[d]) begin
            sr[d] = {sr[d][14:0], o_data[d]};
            nsh[d]++;
          end
          if (o_latch[d] && !platch[d]) begin
            nlatch[d]++;
            check($sformatf("dut%0d latch_phase", d), cyc % f_period(d), 1 + 32 * f_div(d));
            check($sformatf("dut%0d shift_cnt", d), nsh[d], 32'd16);
            if (rp[d] == wp[d]) begin
              check($sformatf("dut%0d exp_avail", d), 32'd0, 32'd1);
            end else begin
              m_e = ebuf[d][rp[d] % 8];
              rp[d]++;
              check($sformatf("dut%0d row_idx", d), 32'(o_row[d]), 32'(m_e[18:16]));
              check($sformatf("dut%0d word r%0d", d, m_e[18:16]), 32'(sr[d]), 32'(m_e[15:0]));
            end
            nsh[d] = 0;
          end
          if (o_fd[d])
            check($sformatf("dut%0d frame_done_time", d), cyc % (8 * f_period(d)), 32'd0);
          else if (cyc > 0 && cyc % (8 * f_period(d)) == 0)
            check($sformatf("dut%0d frame_done_missing", d), 32'(o_fd[d]), 32'd1);
          pclk[d] = o_sclk[d]; platch[d] = o_latch[d]; pdata[d] = o_data[d];
        end
      end
    end
  end

  task automatic run_cycles(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_matrix(input logic [7:0] v);
    for (int i = 0; i < 8; i++) matrix[i] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run_cycles(3);
    reset = 1'b0;
  endtask

  localparam int unsigned FRAME_A = 8 * (1 + 33 * DIV_A + HOLD_A);
  localparam int unsigned FRAME_B = 8 * (1 + 33 * DIV_B + HOLD_B);

  logic found;
  logic first_bit;

  initial begin
    set_matrix(8'h00);
    game_state = 1'b1;
    run_cycles(3);
    reset = 1'b0;
    run_cycles(2 * FRAME_A + 10);

    matrix[3] = 8'hA5;
    run_cycles(2 * FRAME_A);

    // Tear test: row 0 changes while row 4 is shifting; model snapshots only at frame start.
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(posedge clk); #1;
      if (o_row[0] == 3'd4 && o_sclk[0]) found = 1'b1;
    end
    check("wait_row4", 32'(found), 32'd1);
    matrix[0] = 8'hFF;
    run_cycles(2 * FRAME_A);

    // Reset in the middle of a SHIFT_HI phase of row 5.
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(posedge clk); #1;
      if (o_row[0] == 3'd5 && o_sclk[0]) found = 1'b1;
    end
    check("wait_row5_hi", 32'(found), 32'd1);
    matrix[0] = 8'h5A;
    first_bit = matrix[0][7];
    reset = 1'b1;
    run_cycles(3);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_first_bit", 32'(o_data[0]), 32'(first_bit));
    check("post_rst_sclk_low", 32'(o_sclk[0]), 32'd0);
    run_cycles(FRAME_A + 20);

    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 8; i++) matrix[i] = 8'($urandom);
      game_state = ($urandom_range(0, 3) != 0);
      run_cycles($urandom_range(100, 1500));
    end

    // Blink: fast instance alternates every BF_B frames, row-select bits stay intact.
    game_state = 1'b1;
    set_matrix(8'hFF);
    do_reset();
    game_state = 1'b0;
    run_cycles(12 * FRAME_B + 5);

    for (int d = 0; d < 2; d++)
      check($sformatf("dut%0d latched_any", d), 32'(nlatch[d] > 0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_matrix_scanner.md
# led_matrix_scanner

Row-scanning driver for the 8x8 LED play-field. It reads the 8-row settled play-field matrix and the game-state flag from the game logic. It serialises one row at a time into an external 16-bit shift-register chain (8 column bits followed by 8 row-select bits) and latches each row for a fixed hold time. The matrix is snapshotted once per frame so that mid-frame updates never tear the image. When the game is over, the whole field blinks.

## Interface
- DIV, default 2: clk cycles per ser_clk phase (low and high each last DIV cycles); legal range ≥1.
- HOLD, default 64: clk cycles a latched row is displayed before the next row starts shifting.
- BLINK_FRAMES, default 32: frames per blink phase while game is over.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- matrix[0:7]  in  8 each  play-field rows; row 0 = top; bit 7 = leftmost column.
- game_state  in  1  1 = playing, 0 = game over.
- ser_data  out  1  serial data to the shift chain; reset 0.
- ser_clk  out  1  shift clock, data sampled externally on its rising edge; reset 0.
- ser_latch  out  1  storage-register latch, active high; reset 0.
- row_idx  out  3  row currently latched or being shifted; reset 0.
- frame_done  out  1  one-cycle pulse after row 7's hold completes; reset 0.

## Operation
- FSM states: LOAD, SHIFT_LO, SHIFT_HI, LATCH, HOLD.
- Reset enters LOAD with row_idx=0, blink_on=1, blink frame count 0, and all outputs 0.
- **LOAD** (1 cycle):
  - If row_idx==0, copy all 8 matrix rows into the snapshot.
  - Build the 16-bit word: bits[15:8] = snapshot[row_idx] AND a mask. The mask is 8'hFF when game_state==1 or blink_on==1, and 8'h00 otherwise.
  - bits[7:0] = one-hot row select, 8'b1000_0000 >> row_idx.
  - Go to SHIFT_LO with bit count 15.
- **SHIFT_LO** (DIV cycles):
  - ser_clk=0 and ser_data = word[bit count].
  - Then go to SHIFT_HI.
- **SHIFT_HI** (DIV cycles):
  - ser_clk=1 and ser_data held.
  - If bit count==0, go to LATCH. Otherwise decrement the bit count and go to SHIFT_LO.
- **LATCH** (DIV cycles):
  - ser_latch=1, ser_clk=0, ser_data=0.
  - Then go to HOLD.
- **HOLD** (HOLD cycles): all serial outputs are 0.
  - At the end, if row_idx==7, pulse frame_done, set row_idx to 0, and update the blink state.
  - Otherwise increment row_idx.
  - Then go to LOAD.
- Blink update at each frame end:
  - While game_state==0, the frame count increments. At BLINK_FRAMES−1 it wraps to 0 and blink_on toggles.
  - While game_state==1, the frame count is 0 and blink_on is 1.
- game_state is sampled only in LOAD. A change mid-row takes effect on the next row.
- row_idx is 3-bit and wraps 7→0 naturally. It must never skip or repeat a row.

## Timing
- Row period = 1 + 32·DIV + DIV + HOLD cycles. With defaults: 1+64+2+64 = 131.
- Frame period = 8 × row period = 1048 cycles with defaults.
- Bit order is MSB first: 8 column bits (col 7..0), then 8 row-select bits.
- ser_data is stable for the full SHIFT_LO+SHIFT_HI window. It changes only on entry to SHIFT_LO.
- ser_latch rises exactly one cycle after the 16th SHIFT_HI phase ends.
- frame_done is asserted in the cycle that LOAD for row 0 begins.
- The snapshot captures matrix only in the LOAD of row 0. Changes on matrix during rows 0–7 appear in the next frame.
- Reset asserted mid-shift immediately forces all outputs to 0 and the FSM to LOAD with row 0. The first LOAD after release takes a new snapshot.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Defaults, matrix all zero, game_state=1 → per row: 16 bits = 8'h00 followed by the one-hot select. Row 0 word = 16'h0080, row 7 word = 16'h0001. Latch pulses are 131 cycles apart. frame_done pulses every 1048 cycles.
- matrix[3]=8'hA5, other rows 0 → the row-3 word is 16'hA510. Decode with a bench shift-register model clocked on ser_clk rising edges and captured on ser_latch.
- Change matrix[0] from 8'h00 to 8'hFF while row 4 is shifting → rows 5–7 of that frame are unchanged. Row 0 of the next frame shows 8'hFF.
- game_state=0 with matrix all 8'hFF → 32 frames with column bits 8'hFF, then 32 frames with 8'h00, alternating. Row-select bits are never masked.
- Assert reset for 3 cycles mid-SHIFT_HI of row 5 → outputs are 0 during reset. After release, the row-0 word starts with the correct first bit on the first SHIFT_LO, 1 cycle after LOAD.
- DIV=1, HOLD=1 → row period = 1+32+1+1 = 35 cycles. Each ser_clk phase is exactly 1 cycle.
